// File: rtl/proyecto_fir_fifo.sv
// proyecto_fir_fifo: sixteen-tap direct-form FIR filter with live coefficients,
// feeding a power-of-two output FIFO that a downstream reader drains.
// Optional feature: define FIR_SAT_EN to saturate the scaled filter output to
// the 16-bit signed range. Without it the scaled value wraps (acc[26:11]).
module proyecto_fir_fifo #(
    parameter int FIFO_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               control,
    input  logic signed [11:0] data_in,
    input  logic signed [11:0] coef0,
    input  logic signed [11:0] coef1,
    input  logic signed [11:0] coef2,
    input  logic signed [11:0] coef3,
    input  logic signed [11:0] coef4,
    input  logic signed [11:0] coef5,
    input  logic signed [11:0] coef6,
    input  logic signed [11:0] coef7,
    input  logic signed [11:0] coef8,
    input  logic signed [11:0] coef9,
    input  logic signed [11:0] coef10,
    input  logic signed [11:0] coef11,
    input  logic signed [11:0] coef12,
    input  logic signed [11:0] coef13,
    input  logic signed [11:0] coef14,
    input  logic signed [11:0] coef15,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic signed [15:0] dato_out,
    output logic               full,
    output logic               empty
);

    localparam int TAPS = 16;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    // ------------------------------------------------------------------
    // FIR datapath
    // ------------------------------------------------------------------
    logic signed [11:0] coef [TAPS];
    logic signed [11:0] x    [TAPS];
    logic signed [23:0] prod [TAPS];
    logic signed [27:0] acc;
    logic signed [15:0] y_next;
    logic signed [15:0] y;

    assign coef[0]  = coef0;
    assign coef[1]  = coef1;
    assign coef[2]  = coef2;
    assign coef[3]  = coef3;
    assign coef[4]  = coef4;
    assign coef[5]  = coef5;
    assign coef[6]  = coef6;
    assign coef[7]  = coef7;
    assign coef[8]  = coef8;
    assign coef[9]  = coef9;
    assign coef[10] = coef10;
    assign coef[11] = coef11;
    assign coef[12] = coef12;
    assign coef[13] = coef13;
    assign coef[14] = coef14;
    assign coef[15] = coef15;

    // Delay line: newest sample in x[0], shifts only while the filter is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else if (control) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // tap samples its neighbour's pre-edge value; blocking here would
            // collapse the whole shift register into one stage.
            x[0] <= data_in;
            for (int i = 1; i < TAPS; i++) begin
                x[i] <= x[i-1];
            end
        end
    end

    // Exact 24-bit tap products (12x12 signed).
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = coef[i] * x[i];
        end
    end

    // Exact 28-bit sum of all sixteen products.
    always_comb begin
        // NOTE: a combinational variable gets a value before any conditional
        // or loop logic touches it; leaving a path unassigned infers a latch.
        acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + 28'(prod[i]);
        end
    end

`ifdef FIR_SAT_EN
    logic signed [27:0] shifted;

    // Floor-scale by 2^11, then clamp to the 16-bit signed range.
    always_comb begin
        shifted = acc >>> 11;
        if (shifted[27:15] == {13{shifted[15]}}) begin
            y_next = shifted[15:0];
        end else if (shifted[27]) begin
            y_next = 16'sh8000;
        end else begin
            y_next = 16'sh7FFF;
        end
    end
`else
    // Floor-scale by 2^11 and keep the low 16 bits (wrap-around).
    assign y_next = 16'(acc >>> 11);
`endif

    // Output register: loads from the pre-edge delay line while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else if (control) begin
            y <= y_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_wr;
    logic          do_rd;

    // A write while full and a read while empty are simply blocked here,
    // which also covers every simultaneous read/write corner case.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Next occupancy; a concurrent read and write leave it unchanged.
    always_comb begin
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are never
        // visible because occupancy and pointers are reset instead.
        if (do_wr) begin
            mem[wr_ptr] <= y;
        end
    end

    // Pointers, occupancy, registered flags and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            dato_out <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                dato_out <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CW'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_proyecto_fir_fifo.sv
// Testbench for proyecto_fir_fifo: a behavioural filter model plus a queue
// scoreboard of FIFO contents, checked against the DUT every clock.
// Honours FIR_SAT_EN the same way the design does.
module tb_proyecto_fir_fifo;

    localparam int DEPTH = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic               control;
    logic signed [11:0] data_in;
    logic signed [11:0] coef [16];
    logic               wr_en;
    logic               rd_en;
    logic signed [15:0] dato_out;
    logic               full;
    logic               empty;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int                 m_x [16];
    logic signed [15:0] m_y;
    logic signed [15:0] exp_dout;
    logic signed [15:0] sb [$];

    always #5 clk = ~clk;

    proyecto_fir_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .control  (control),
        .data_in  (data_in),
        .coef0    (coef[0]),
        .coef1    (coef[1]),
        .coef2    (coef[2]),
        .coef3    (coef[3]),
        .coef4    (coef[4]),
        .coef5    (coef[5]),
        .coef6    (coef[6]),
        .coef7    (coef[7]),
        .coef8    (coef[8]),
        .coef9    (coef[9]),
        .coef10   (coef[10]),
        .coef11   (coef[11]),
        .coef12   (coef[12]),
        .coef13   (coef[13]),
        .coef14   (coef[14]),
        .coef15   (coef[15]),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .dato_out (dato_out),
        .full     (full),
        .empty    (empty)
    );

    // Filter output from the model delay line, using integer arithmetic.
    function automatic logic signed [15:0] model_y();
        longint acc;
        longint sh;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += longint'(int'(coef[i])) * longint'(m_x[i]);
        end
        sh = acc >>> 11;
`ifdef FIR_SAT_EN
        if (sh > 32767)  return 16'sh7FFF;
        if (sh < -32768) return 16'sh8000;
        return 16'(sh);
`else
        return 16'(sh);
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_x[i] = 0;
        m_y      = '0;
        exp_dout = '0;
        sb.delete();
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare read data and flags on the falling edge.
    task automatic tick(input string tag);
        bit   do_wr;
        bit   do_rd;
        logic exp_empty;
        logic exp_full;
        @(posedge clk);
        do_rd = rd_en && (sb.size() > 0);
        do_wr = wr_en && (sb.size() < DEPTH);
        if (do_rd) exp_dout = sb.pop_front();
        if (do_wr) sb.push_back(m_y);
        if (control) begin
            m_y = model_y();
            for (int i = 15; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0] = int'(data_in);
        end
        exp_empty = (sb.size() == 0);
        exp_full  = (sb.size() == DEPTH);
        @(negedge clk);
        checks++;
        if (dato_out !== exp_dout) begin
            failures++;
            $display("FAIL %s dato_out: got %0d expected %0d", tag, dato_out, exp_dout);
        end
        checks++;
        if (empty !== exp_empty) begin
            failures++;
            $display("FAIL %s empty: got %b expected %b", tag, empty, exp_empty);
        end
        checks++;
        if (full !== exp_full) begin
            failures++;
            $display("FAIL %s full: got %b expected %b", tag, full, exp_full);
        end
    endtask

    task automatic idle_inputs();
        control = 1'b0;
        data_in = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_clear();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_symmetric();
        int tbl [16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                         854, 376, -86, -156, 33, 136, 65, -99};
        for (int i = 0; i < 16; i++) coef[i] = 12'(tbl[i]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) coef[i] = '0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_clear();
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty: got %b expected 1", empty);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full: got %b expected 0", full);
        end
        checks++;
        if (dato_out !== 16'sh0000) begin
            failures++;
            $display("FAIL reset_dato_out: got %0d expected 0", dato_out);
        end
        rst = 1'b1;
        rd_en = 1'b1;
        tick("reset_rd_pulse");
        rd_en = 1'b0;
        tick("reset_rd_after");
    endtask

    task automatic test_symmetric();
        do_reset(2);
        set_symmetric();
        control = 1'b1;
        data_in = -12'sd1;
        wr_en   = 1'b1;
        for (int t = 0; t < 20; t++) tick("sym_fill");
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int r = 0; r < 20; r++) begin
            tick("sym_drain");
            if (r == 0) begin
                checks++;
                if (dato_out !== 16'sh0000) begin
                    failures++;
                    $display("FAIL sym_first: got %0d expected 0", dato_out);
                end
            end
            if (r == 17) begin
                checks++;
                if (dato_out !== 16'hFFFE) begin
                    failures++;
                    $display("FAIL sym_steady: got %0d expected -2", dato_out);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_impulse();
        int imp [17] = '{-99, 64, 135, 32, -156, -86, 375, 853,
                         853, 375, -86, -156, 32, 135, 64, -99, 0};
        do_reset(2);
        set_symmetric();
        control = 1'b1;
        wr_en   = 1'b1;
        data_in = 12'sd2047;
        tick("imp_fill");
        data_in = '0;
        for (int t = 1; t < 20; t++) tick("imp_fill");
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int r = 0; r < 20; r++) begin
            tick("imp_drain");
            if (r >= 2 && r <= 18) begin
                checks++;
                if (dato_out !== 16'(imp[r-2])) begin
                    failures++;
                    $display("FAIL imp_tap%0d: got %0d expected %0d", r - 2, dato_out, imp[r-2]);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic fill_random(input string tag);
        for (int i = 0; i < 16; i++) coef[i] = 12'($urandom);
        control = 1'b1;
        wr_en   = 1'b1;
        for (int t = 0; t < DEPTH; t++) begin
            data_in = 12'($urandom);
            tick(tag);
        end
    endtask

    task automatic test_fill_drain();
        do_reset(2);
        fill_random("fill");
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got %b expected 1", full);
        end
        for (int t = 0; t < 4; t++) begin
            data_in = 12'($urandom);
            tick("fill_overflow");
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            data_in = 12'($urandom);
            tick("drain");
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty: got %b expected 1", empty);
        end
        tick("drain_underflow");
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        set_symmetric();
        control = 1'b1;
        // Read and write while empty: only the write happens
        data_in = 12'sd500;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick("b2b_empty");
        rd_en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            data_in = 12'($urandom);
            tick("b2b_prime");
        end
        rd_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            data_in = 12'($urandom);
            tick("b2b_stream");
        end
        rd_en = 1'b0;
        fill_random("b2b_fill");
        // Read and write while full: only the read happens
        rd_en = 1'b1;
        tick("b2b_full");
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_clear: got %b expected 0", full);
        end
        wr_en = 1'b0;
        for (int r = 0; r < DEPTH; r++) tick("b2b_drain");
        rd_en = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset(2);
        for (int i = 0; i < 16; i++) coef[i] = -12'sd2048;
        control = 1'b1;
        data_in = -12'sd2048;
        for (int t = 0; t < 17; t++) tick("sat_fill");
        wr_en = 1'b1;
        tick("sat_write");
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick("sat_read");
        rd_en = 1'b0;
        checks++;
`ifdef FIR_SAT_EN
        if (dato_out !== 16'h7FFF) begin
            failures++;
            $display("FAIL sat_value: got %h expected 7fff", dato_out);
        end
`else
        if (dato_out !== 16'h8000) begin
            failures++;
            $display("FAIL wrap_value: got %h expected 8000", dato_out);
        end
`endif
    endtask

    task automatic test_hold();
        do_reset(2);
        set_symmetric();
        control = 1'b1;
        for (int t = 0; t < 10; t++) begin
            data_in = 12'($urandom);
            tick("hold_load");
        end
        control = 1'b0;
        wr_en   = 1'b1;
        for (int t = 0; t < 6; t++) begin
            data_in = t[0] ? 12'sd2047 : -12'sd2048;
            tick("hold_toggle");
        end
        control = 1'b1;
        for (int t = 0; t < 4; t++) begin
            data_in = '0;
            tick("hold_resume");
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int r = 0; r < 12; r++) tick("hold_drain");
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        set_symmetric();
        control = 1'b1;
        wr_en   = 1'b1;
        for (int t = 0; t < 12; t++) begin
            data_in = 12'($urandom);
            rd_en   = (t > 6);
            tick("mid_burst");
        end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_empty: got %b expected 1", empty);
        end
        checks++;
        if (dato_out !== 16'sh0000) begin
            failures++;
            $display("FAIL mid_reset_dato_out: got %0d expected 0", dato_out);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_full: got %b expected 0", full);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        rd_en = 1'b0;
        // First write after release captures y, which reset cleared to zero
        for (int t = 0; t < 4; t++) begin
            data_in = 12'sd1000;
            tick("mid_resume");
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick("mid_read_first");
        checks++;
        if (dato_out !== 16'sh0000) begin
            failures++;
            $display("FAIL mid_y_cleared: got %0d expected 0", dato_out);
        end
        for (int r = 0; r < 4; r++) tick("mid_read");
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 16; i++) coef[i] = '0;
        model_clear();
        test_reset();
        test_symmetric();
        test_impulse();
        test_saturation();
        test_hold();
        test_back_to_back();
        test_fill_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
